// File: rtl/prio_enc_seg.sv
// rtl/prio_enc_seg.sv - registered priority encoder with hold-max, change counter and hex display
module prio_enc_seg_glyph (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    // active-low, bit0 = a ... bit6 = g
    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module prio_enc_seg #(
    parameter  int WIDTH = 8,
    localparam int IDXW  = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    output logic [IDXW-1:0]  idx,
    output logic             valid,
    output logic             eno,
    output logic [7:0]       chg_cnt,
    output logic [6:0]       seg_lo,
    output logic [6:0]       seg_hi
);
    logic [WIDTH-1:0] in_m_q, in_s_q;
    logic [2:0]       ctl_m_q, ctl_s_q;
    logic             en_s, mode_s, clr_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_m_q  <= '0;
            in_s_q  <= '0;
            ctl_m_q <= '0;
            ctl_s_q <= '0;
        end else begin
            in_m_q  <= in;
            in_s_q  <= in_m_q;
            ctl_m_q <= {clr, mode, en};
            ctl_s_q <= ctl_m_q;
        end
    end

    assign en_s   = ctl_s_q[0];
    assign mode_s = ctl_s_q[1];
    assign clr_s  = ctl_s_q[2];

    logic            any;
    logic [IDXW-1:0] enc;

    always_comb begin
        any = 1'b0;
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_s_q[i]) begin
                any = 1'b1;
                enc = IDXW'(i);
            end
        end
    end

    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            eno_q, eno_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;

    // pend_q marks an encode-driven change of {valid, idx}; it is counted one edge later
    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        eno_d   = en_s & ~any;
        if (clr_s) begin
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = 8'd0;
        end else if (!en_s) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else begin
            cnt_d = cnt_q + {7'd0, pend_q};
            if (!mode_s) begin
                idx_d   = enc;
                valid_d = any;
            end else if (any && (!valid_q || (enc > idx_q))) begin
                idx_d   = enc;
                valid_d = 1'b1;
            end
            pend_d = (idx_d != idx_q) || (valid_d != valid_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            eno_q   <= 1'b0;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            eno_q   <= eno_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    logic [7:0] idx_ext;
    logic [6:0] glyph_lo, glyph_hi;

    assign idx_ext = 8'(idx_q);

    prio_enc_seg_glyph u_glyph_lo (
        .nib_i (idx_ext[3:0]),
        .seg_o (glyph_lo)
    );

    prio_enc_seg_glyph u_glyph_hi (
        .nib_i (idx_ext[7:4]),
        .seg_o (glyph_hi)
    );

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign eno     = eno_q;
    assign chg_cnt = cnt_q;
    assign seg_lo  = valid_q ? glyph_lo : 7'h7F;
    assign seg_hi  = valid_q ? glyph_hi : 7'h7F;
endmodule

// File: tb/tb_prio_enc_seg.sv
// tb/tb_prio_enc_seg.sv - randomized and directed bench for prio_enc_seg at WIDTH 8 and 32
module tb_prio_enc_seg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_v = 1'b0;
    logic [31:0] in_v    = '0;
    logic        en_v    = 1'b0;
    logic        mode_v  = 1'b0;
    logic        clr_v   = 1'b0;

    logic [2:0] d8_idx;
    logic       d8_valid, d8_eno;
    logic [7:0] d8_cnt;
    logic [6:0] d8_lo, d8_hi;
    logic [4:0] d32_idx;
    logic       d32_valid, d32_eno;
    logic [7:0] d32_cnt;
    logic [6:0] d32_lo, d32_hi;

    prio_enc_seg #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n_v), .in(in_v[7:0]), .en(en_v), .mode(mode_v), .clr(clr_v),
        .idx(d8_idx), .valid(d8_valid), .eno(d8_eno), .chg_cnt(d8_cnt),
        .seg_lo(d8_lo), .seg_hi(d8_hi)
    );

    prio_enc_seg #(.WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n_v), .in(in_v), .en(en_v), .mode(mode_v), .clr(clr_v),
        .idx(d32_idx), .valid(d32_valid), .eno(d32_eno), .chg_cnt(d32_cnt),
        .seg_lo(d32_lo), .seg_hi(d32_hi)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference glyphs written active-high (gfedcba) and inverted
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] on;
        case (v & 15)
            0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
            4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
            8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
            12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    function automatic int top_bit(input logic [31:0] v, input int w);
        for (int b = w - 1; b >= 0; b--)
            if (v[b]) return b;
        return -1;
    endfunction

    // Model: two-deep input history, then the spec's rules per edge
    logic [31:0] h_in[2];
    logic        h_en[2], h_mode[2], h_clr[2];
    int m_idx[2], m_valid[2], m_eno[2], m_cnt[2], m_pend[2];

    task automatic model_edge();
        if (!rst_n_v) begin
            for (int k = 0; k < 2; k++) begin
                h_in[k] = '0; h_en[k] = 1'b0; h_mode[k] = 1'b0; h_clr[k] = 1'b0;
                m_idx[k] = 0; m_valid[k] = 0; m_eno[k] = 0; m_cnt[k] = 0; m_pend[k] = 0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int w, t, e, ni, nv;
            logic any;
            w   = (k == 0) ? 8 : 32;
            t   = top_bit(h_in[1], w);
            any = (t >= 0);
            e   = any ? t : 0;
            m_eno[k] = (h_en[1] && !any) ? 1 : 0;
            if (h_clr[1]) begin
                m_idx[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_pend[k] = 0;
            end else if (!h_en[1]) begin
                m_idx[k] = 0; m_valid[k] = 0; m_pend[k] = 0;
            end else begin
                m_cnt[k] = (m_cnt[k] + m_pend[k]) % 256;
                ni = m_idx[k];
                nv = m_valid[k];
                if (!h_mode[1]) begin
                    ni = e; nv = any ? 1 : 0;
                end else if (any) begin
                    ni = m_valid[k] ? ((e > m_idx[k]) ? e : m_idx[k]) : e;
                    nv = 1;
                end
                m_pend[k] = (ni != m_idx[k] || nv != m_valid[k]) ? 1 : 0;
                m_idx[k]   = ni;
                m_valid[k] = nv;
            end
        end
        h_in[1] = h_in[0]; h_en[1] = h_en[0]; h_mode[1] = h_mode[0]; h_clr[1] = h_clr[0];
        h_in[0] = in_v;    h_en[0] = en_v;    h_mode[0] = mode_v;    h_clr[0] = clr_v;
    endtask

    function automatic logic [6:0] exp_seg(input int v, input int nib);
        return (v != 0) ? glyph(nib) : 7'h7F;
    endfunction

    task automatic compare_all();
        check_eq("idx8",    d8_idx,    m_idx[0]);
        check_eq("valid8",  d8_valid,  m_valid[0]);
        check_eq("eno8",    d8_eno,    m_eno[0]);
        check_eq("cnt8",    d8_cnt,    m_cnt[0]);
        check_eq("seglo8",  d8_lo,     exp_seg(m_valid[0], m_idx[0] % 16));
        check_eq("seghi8",  d8_hi,     exp_seg(m_valid[0], m_idx[0] / 16));
        check_eq("idx32",   d32_idx,   m_idx[1]);
        check_eq("valid32", d32_valid, m_valid[1]);
        check_eq("eno32",   d32_eno,   m_eno[1]);
        check_eq("cnt32",   d32_cnt,   m_cnt[1]);
        check_eq("seglo32", d32_lo,    exp_seg(m_valid[1], m_idx[1] % 16));
        check_eq("seghi32", d32_hi,    exp_seg(m_valid[1], m_idx[1] / 16));
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_idx"},   d8_idx,   0);
        check_eq({tag, "_valid"}, d8_valid, 0);
        check_eq({tag, "_eno"},   d8_eno,   0);
        check_eq({tag, "_cnt"},   d8_cnt,   0);
        check_eq({tag, "_seglo"}, d8_lo,    7'h7F);
        check_eq({tag, "_seghi"}, d8_hi,    7'h7F);
        check_eq({tag, "_cnt32"}, d32_cnt,  0);
    endtask

    int saved_cnt;

    initial begin
        // reset
        step(2);
        check_reset_vals("rst");
        rst_n_v = 1'b1; en_v = 1'b1;
        step(2);
        check_eq("eno_edge2", d8_eno, 0);
        step(1);
        check_eq("eno_edge3", d8_eno, 1);

        // live priority
        in_v = 32'h16;
        step(3);
        check_eq("live_idx4",  d8_idx,   4);
        check_eq("live_val",   d8_valid, 1);
        check_eq("live_seglo", d8_lo,    glyph(4));
        check_eq("live_seghi", d8_hi,    glyph(0));
        check_eq("live_eno",   d8_eno,   0);
        in_v = 32'h81;
        step(3);
        check_eq("live_idx7", d8_idx, 7);
        in_v = 32'h0;
        step(4);
        check_eq("live_val0", d8_valid, 0);
        check_eq("live_blank", d8_lo, 7'h7F);
        check_eq("live_cnt3", d8_cnt, 3);

        // hold maximum
        mode_v = 1'b1; in_v = 32'h04;
        step(3);
        check_eq("hold_2", d8_idx, 2);
        in_v = 32'h40;
        step(3);
        check_eq("hold_6a", d8_idx, 6);
        in_v = 32'h02;
        step(3);
        check_eq("hold_6b", d8_idx, 6);
        in_v = 32'h00;
        step(3);
        check_eq("hold_6c", d8_idx, 6);
        check_eq("hold_val", d8_valid, 1);
        check_eq("hold_eno", d8_eno, 1);
        step(1);
        check_eq("hold_cnt5", d8_cnt, 5);

        // reset mid-operation
        rst_n_v = 1'b0;
        step(1);
        check_reset_vals("midrst");
        rst_n_v = 1'b1;

        // clear pulse in hold mode
        in_v = 32'h40;
        step(4);
        check_eq("hold_re6", d8_idx, 6);
        in_v = 32'h0;
        step(1);
        clr_v = 1'b1;
        step(1);
        clr_v = 1'b0;
        step(4);
        check_eq("clr_idx", d8_idx, 0);
        check_eq("clr_val", d8_valid, 0);
        check_eq("clr_cnt", d8_cnt, 0);
        mode_v = 1'b0; in_v = 32'h02;
        step(3);
        check_eq("live_idx1", d8_idx, 1);

        // enable gate
        in_v = 32'h80;
        step(4);
        check_eq("en_idx7", d8_idx, 7);
        saved_cnt = m_cnt[0];
        en_v = 1'b0;
        step(4);
        check_eq("en0_idx", d8_idx, 0);
        check_eq("en0_val", d8_valid, 0);
        check_eq("en0_eno", d8_eno, 0);
        check_eq("en0_cnt", d8_cnt, saved_cnt);
        en_v = 1'b1;
        step(4);
        check_eq("en1_idx", d8_idx, 7);
        check_eq("en1_cnt", d8_cnt, (saved_cnt + 1) % 256);

        // wide index and counter wrap
        in_v = 32'h1 << 29;
        step(3);
        check_eq("wide_idx", d32_idx, 29);
        check_eq("wide_seghi", d32_hi, glyph(1));
        check_eq("wide_seglo", d32_lo, glyph(13));
        check_eq("wide_d8val", d8_valid, 0);
        in_v = 32'h1; clr_v = 1'b1;
        step(1);
        clr_v = 1'b0;
        step(6);
        check_eq("wrap_start", d32_cnt, 1);
        for (int i = 0; i < 255; i++) begin
            in_v = in_v ^ 32'h3;
            step(1);
        end
        step(5);
        check_eq("wrap_cnt32", d32_cnt, 0);
        check_eq("wrap_cnt8",  d8_cnt,  0);

        // randomized run against the model
        for (int i = 0; i < 2000; i++) begin
            in_v    = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            en_v    = ($urandom_range(0, 15) != 0);
            clr_v   = ($urandom_range(0, 31) == 0);
            rst_n_v = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) mode_v = ~mode_v;
            step(1);
        end
        rst_n_v = 1'b1;
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prio_enc_seg.md
# prio_enc_seg

Parametrised, registered priority encoder with cascade enable, hold-maximum mode, change counter and two-digit hex seven-segment display of the winning index. It succeeds the team's fixed 8-to-3 combinational encoder and drives NVBoard switches-to-display demos. Inputs are synchronised internally, so raw switch levels may be connected directly.

## Interface
- `WIDTH`, default 8: number of request inputs, legal 2..256.
- `IDXW`: localparam, `max(1, clog2(WIDTH))`; index width, at most 8.
- `clk`, input, 1 bit: single clock, all state on rising edge.
- `rst_n`, input, 1 bit: reset, synchronous, active-low.
- `in`, input, WIDTH bits: request lines; bit WIDTH-1 has highest priority.
- `en`, input, 1 bit: block enable.
- `mode`, input, 1 bit: 0 = live, 1 = hold-maximum.
- `clr`, input, 1 bit: clears the hold register and the change counter.
- `idx`, output, IDXW bits: encoded index of the highest set request.
- `valid`, output, 1 bit: `idx` is meaningful.
- `eno`, output, 1 bit: cascade enable, high when `en`=1 and no request is set.
- `chg_cnt`, output, 8 bits: count of changes on {valid, idx}.
- `seg_lo`, output, 7 bits: low hex digit of `idx`, active-low, bit0 = a through bit6 = g.
- `seg_hi`, output, 7 bits: high hex digit of `idx` (bits 7:4, zero-extended), same encoding.

## Operation
- **Input path:**
  - `in`, `en`, `mode` and `clr` pass through a 2-flop synchroniser.
  - All logic below uses the synchronised copies (`in_s`, `en_s`, `mode_s`, `clr_s`).
- **Encode (combinational on `in_s`):**
  - `any` = OR of `in_s`.
  - `enc` = position of the highest set bit, 0 when `any`=0.
- **Live mode (`mode_s`=0), registered each cycle:**
  - `idx` <= `enc`.
  - `valid` <= `any`.
- **Hold mode (`mode_s`=1):**
  - If `any` and (`!valid` or `enc` > `idx`): `idx` <= `enc`, `valid` <= 1.
  - Otherwise `idx` and `valid` hold.
  - The held value never decreases while in hold mode.
- **Mode switches:**
  - hold -> live: the next cycle reloads from `enc`.
  - live -> hold: the current `idx`/`valid` are the starting point.
- **`clr_s`=1:**
  - `idx` <= 0, `valid` <= 0, `chg_cnt` <= 0.
  - Overrides the encode update in the same cycle.
- **`en_s`=0:**
  - `idx` <= 0, `valid` <= 0, `eno` <= 0.
  - `chg_cnt` is frozen; this forced clear is not counted as a change.
  - `clr_s` still clears `chg_cnt`.
- **`eno`:** registered, `eno` <= `en_s` & ~`any`. It is independent of mode, so in hold mode `eno` may be 1 while `valid` is 1.
- **Change counter:**
  - `chg_cnt` increments by 1 in the cycle after the registered {valid, idx} differs from its previous value, with `en_s`=1 and `clr_s`=0.
  - 8-bit, wraps 255 -> 0 without saturation.
- **Seven-segment:**
  - Combinational from registered `idx`/`valid`.
  - Hex glyphs 0-F, active-low.
  - `valid`=0 blanks both digits (7'h7F).
  - When IDXW <= 4, `seg_hi` always shows 0 while valid.

## Timing
- **Reset values:** `idx`=0, `valid`=0, `eno`=0, `chg_cnt`=0, `seg_lo`=`seg_hi`=7'h7F. Synchroniser flops are cleared to 0.
- **Latency:** a change on `in` appears on `idx`/`valid`/`eno` at the 3rd rising edge after it: 2 synchroniser edges plus 1 register edge. `seg_*` follow in the same cycle.
- **`chg_cnt`:** updates 1 edge after `idx`/`valid`, i.e. 4 edges after an input change.
- **`en`, `clr`, `mode`:** take effect 3 edges after assertion, aligned with the data path.
- **Reset mid-operation:** `rst_n` low at any edge forces all reset values at that edge, including the hold register and the counter. Outputs resume 3 edges after the first edge sampling `rst_n`=1 with stable inputs.
- **Simultaneous events:**
  - Priority is `clr` > `en`=0 > mode update.
  - Multiple set bits resolve to the highest index.
- **No handshake:** `in` may change every cycle. Each input value is reflected in `idx` 3 cycles later, with no skipped cycles.

## Test plan
- **Reset:** WIDTH=8, `rst_n`=0 for 2 cycles -> `idx`=0, `valid`=0, `eno`=0, `chg_cnt`=0, both segs 7'h7F. Then `en`=1, `in`=0 -> `eno`=1 at edge 3.
- **Live priority:** WIDTH=8, `en`=1, `mode`=0; drive `in`=8'b0001_0110 -> `idx`=4, `valid`=1, `seg_lo`=glyph 4, `seg_hi`=glyph 0, `eno`=0 exactly 3 edges later. Then `in`=8'b1000_0001 -> `idx`=7. Then `in`=0 -> `valid`=0, segs blank; `chg_cnt`=3.
- **Hold max:** `mode`=1; apply `in`=0x04, 0x40, 0x02, 0x00 in sequence -> `idx` goes 2, 6, 6, 6 with `valid` staying 1. `clr` pulse -> `idx`=0, `valid`=0, `chg_cnt`=0. Return to `mode`=0 with `in`=0x02 -> `idx`=1.
- **Enable gate:** `in`=0x80, `en` dropped to 0 -> `idx`=0, `valid`=0, `eno`=0, `chg_cnt` unchanged. Re-enable -> `idx`=7, and the counter increments once.
- **Wide/wrap:** WIDTH=32, `in`=1<<29 -> `idx`=29, `seg_hi`=glyph 1, `seg_lo`=glyph D. Toggle `in` between bit 0 and bit 1 for 256 changes -> `chg_cnt` wraps to 0.
- **Reset mid-operation:** in hold mode with `idx`=6, `chg_cnt`=5, assert `rst_n`=0 for 1 edge -> all outputs at their reset values on that edge.
